instr_fetch_stage: RTL and testbench

//  Fetch stage of the 24-bit CPU. Holds the PC and fetches 24-bit instruction words over a req/ready handshake.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/instr_fetch_stage_if_id_reg.sv | 28 ++
 rtl/instr_fetch_stage.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit CPU: field widths, opcode encodings and fetch-state encoding.
package cpu_pkg;

    localparam int unsigned DATA_W   = 24;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_R   = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_I   = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_LS  = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SS  = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 4'b0100;

    localparam logic [DATA_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetchState_e;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble and wins over load; otherwise holds.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] instrIn,
    input  logic [ADDR_W-1:0] pcNextIn,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pcNext
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid  <= 1'b0;
            instr  <= NOP_INSTR;
            pcNext <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            instr  <= instrIn;
            pcNext <= pcNextIn;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, request FSM and 1-entry skid; feeds the IF/ID register for decode.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic [DATA_W-1:0]   imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic                if_id_valid,
    output logic [DATA_W-1:0]   if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc_next,
    output logic [OPCODE_W-1:0] if_id_opcode
);

    fetchState_e       state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext, reqAddr, reqAddrNext, pcInc;
    logic              reqNext, squash, squashNext;
    logic              skidValid, skidValidNext;
    logic [DATA_W-1:0] skidInstr, skidInstrNext;
    logic [ADDR_W-1:0] skidPc, skidPcNext;
    logic              ifLoad, ifFlush;
    logic [DATA_W-1:0] ldInstr;
    logic [ADDR_W-1:0] ldPcNext;

    assign pcInc     = pc + ADDR_W'(1);
    // Address has its own register so a squashed request keeps its address while pc already holds the target.
    assign imem_addr = reqAddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            reqAddr   <= RESET_PC;
            imem_req  <= 1'b0;
            squash    <= 1'b0;
            skidValid <= 1'b0;
            skidInstr <= '0;
            skidPc    <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            reqAddr   <= reqAddrNext;
            imem_req  <= reqNext;
            squash    <= squashNext;
            skidValid <= skidValidNext;
            skidInstr <= skidInstrNext;
            skidPc    <= skidPcNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        reqAddrNext   = reqAddr;
        reqNext       = imem_req;
        squashNext    = squash;
        skidValidNext = skidValid;
        skidInstrNext = skidInstr;
        skidPcNext    = skidPc;
        ifLoad        = 1'b0;
        ifFlush       = 1'b0;
        ldInstr       = imem_rdata;
        ldPcNext      = pcInc;

        if (branch_taken) begin
            pcNext        = branch_target;
            ifFlush       = 1'b1;
            skidValidNext = 1'b0;
            stateNext     = FETCH;
            reqNext       = 1'b1;
            if (imem_req && !imem_ready) begin
                squashNext = 1'b1;
            end else begin
                squashNext  = 1'b0;
                reqAddrNext = branch_target;
            end
        end else begin
            case (state)
                IDLE: begin
                    reqNext     = 1'b1;
                    reqAddrNext = pc;
                    stateNext   = FETCH;
                    ifFlush     = !stall;
                end
                FETCH: begin
                    if (imem_req && imem_ready) begin
                        if (squash) begin
                            squashNext  = 1'b0;
                            reqAddrNext = pc;
                            reqNext     = 1'b1;
                            ifFlush     = !stall;
                        end else if (stall) begin
                            skidValidNext = 1'b1;
                            skidInstrNext = imem_rdata;
                            skidPcNext    = pcInc;
                            reqNext       = 1'b0;
                            stateNext     = HOLD;
                        end else begin
                            ifLoad      = 1'b1;
                            pcNext      = pcInc;
                            reqAddrNext = pcInc;
                            reqNext     = 1'b1;
                        end
                    end else begin
                        ifFlush = !stall;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifLoad        = 1'b1;
                        ldInstr       = skidInstr;
                        ldPcNext      = skidPc;
                        pcNext        = pcInc;
                        reqAddrNext   = pcInc;
                        reqNext       = 1'b1;
                        skidValidNext = 1'b0;
                        stateNext     = FETCH;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    if_id_reg u_ifIdReg (
        .clk      (clk),
        .reset    (reset),
        .load     (ifLoad),
        .flush    (ifFlush),
        .instrIn  (ldInstr),
        .pcNextIn (ldPcNext),
        .valid    (if_id_valid),
        .instr    (if_id_instr),
        .pcNext   (if_id_pc_next)
    );

    assign if_id_opcode = if_id_instr[DATA_W-1 -: OPCODE_W];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a latency-programmable instruction memory model.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [23:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        if_id_valid;
    logic [23:0] if_id_instr;
    logic [15:0] if_id_pc_next;
    logic [3:0]  if_id_opcode;

    int unsigned nChecks = 0;
    int unsigned nBad    = 0;

    logic [23:0] mem [0:65535];
    int unsigned lat;
    int unsigned cnt;
    logic        memBlock;

    always #5 clk = ~clk;

    instr_fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc_next (if_id_pc_next),
        .if_id_opcode  (if_id_opcode)
    );

    // Memory answers after lat cycles of a held request; memBlock withholds the answer.
    assign imem_ready = imem_req && !memBlock && (cnt + 1 >= lat);
    assign imem_rdata = imem_ready ? mem[imem_addr] : 24'h0;

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ready) cnt <= 0;
        else                                  cnt <= cnt + 1;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [23:0] exp1 [0:3];
    logic [3:0]  expOp [0:3];

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        memBlock = 1'b0; lat = 1;
        for (int unsigned i = 0; i < 65536; i++) mem[i] = 24'h0;
        mem[0] = 24'h600123; mem[1] = 24'h100456; mem[2] = 24'h200789; mem[3] = 24'h300ABC;
        mem[4] = 24'h011111; mem[5] = 24'h5A5A5A; mem[16'h0040] = 24'h4ABCDE;
        mem[16'h0100] = 24'h3CAFE0; mem[16'hFFFF] = 24'h2DEAD2;
        exp1[0] = 24'h600123; exp1[1] = 24'h100456; exp1[2] = 24'h200789; exp1[3] = 24'h300ABC;
        expOp[0] = 4'h6; expOp[1] = 4'h1; expOp[2] = 4'h2; expOp[3] = 4'h3;

        // 1: reset state, then back-to-back fetch
        doReset();
        checkVal("rst_req", imem_req, 0);
        checkVal("rst_valid", if_id_valid, 0);
        checkVal("rst_instr", if_id_instr, 0);
        checkVal("rst_pcnext", if_id_pc_next, 0);
        checkVal("rst_addr", imem_addr, 0);
        tick();
        checkVal("t1_req", imem_req, 1);
        checkVal("t1_addr0", imem_addr, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("t1_valid", if_id_valid, 1);
            checkVal("t1_instr", if_id_instr, exp1[i]);
            checkVal("t1_opcode", if_id_opcode, expOp[i]);
            checkVal("t1_pcnext", if_id_pc_next, i + 1);
        end

        // 2: three-cycle memory latency
        lat = 3;
        doReset();
        tick();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 3; k++) begin
                checkVal("t2_addr", imem_addr, w);
                if (k > 0) checkVal("t2_bubble", if_id_valid, 0);
                tick();
            end
            checkVal("t2_valid", if_id_valid, 1);
            checkVal("t2_instr", if_id_instr, exp1[w]);
            checkVal("t2_pcnext", if_id_pc_next, w + 1);
        end

        // 3: stall while a response arrives
        lat = 1;
        doReset();
        tick();
        tick();
        checkVal("t3_w0", if_id_instr, 24'h600123);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkVal("t3_holdreq", imem_req, 0);
            checkVal("t3_holdinstr", if_id_instr, 24'h600123);
            checkVal("t3_holdvalid", if_id_valid, 1);
        end
        stall = 1'b0;
        tick();
        checkVal("t3_skid", if_id_instr, 24'h100456);
        checkVal("t3_skidpc", if_id_pc_next, 2);
        checkVal("t3_req", imem_req, 1);
        checkVal("t3_addr", imem_addr, 2);
        tick();
        checkVal("t3_next", if_id_instr, 24'h200789);
        checkVal("t3_nextpc", if_id_pc_next, 3);

        // 4: redirect with a request to 0x0005 outstanding
        doReset();
        repeat (6) tick();
        checkVal("t4_addr5", imem_addr, 5);
        memBlock = 1'b1;
        tick();
        checkVal("t4_pending", imem_addr, 5);
        branch_taken = 1'b1; branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        checkVal("t4_bubble", if_id_valid, 0);
        checkVal("t4_addrheld", imem_addr, 5);
        memBlock = 1'b0;
        tick();
        checkVal("t4_drop_valid", if_id_valid, 0);
        checkVal("t4_drop_instr", if_id_instr, 0);
        checkVal("t4_newaddr", imem_addr, 16'h0040);
        checkVal("t4_newreq", imem_req, 1);
        tick();
        checkVal("t4_tgt_instr", if_id_instr, 24'h4ABCDE);
        checkVal("t4_tgt_pc", if_id_pc_next, 16'h0041);

        // 5: redirect and stall together
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100;
        tick();
        branch_taken = 1'b0;
        checkVal("t5_valid", if_id_valid, 0);
        checkVal("t5_instr", if_id_instr, 0);
        checkVal("t5_addr", imem_addr, 16'h0100);
        tick();
        checkVal("t5_holdreq", imem_req, 0);
        checkVal("t5_holdvalid", if_id_valid, 0);
        stall = 1'b0;
        tick();
        checkVal("t5_instr2", if_id_instr, 24'h3CAFE0);
        checkVal("t5_pc2", if_id_pc_next, 16'h0101);

        // 6: PC wrap, then reset during HOLD
        branch_taken = 1'b1; branch_target = 16'hFFFF;
        tick();
        branch_taken = 1'b0;
        checkVal("t6_addrFFFF", imem_addr, 16'hFFFF);
        tick();
        checkVal("t6_instr", if_id_instr, 24'h2DEAD2);
        checkVal("t6_opcode", if_id_opcode, 4'h2);
        checkVal("t6_wrap_pc", if_id_pc_next, 16'h0000);
        checkVal("t6_wrap_addr", imem_addr, 16'h0000);
        stall = 1'b1;
        tick();
        checkVal("t6_hold", imem_req, 0);
        reset = 1'b1;
        tick();
        checkVal("t6_rst_req", imem_req, 0);
        checkVal("t6_rst_addr", imem_addr, 0);
        checkVal("t6_rst_valid", if_id_valid, 0);
        checkVal("t6_rst_instr", if_id_instr, 0);
        checkVal("t6_rst_pc", if_id_pc_next, 0);
        checkVal("t6_rst_op", if_id_opcode, 0);
        reset = 1'b0; stall = 1'b0;
        tick();
        checkVal("t6_idle_req", imem_req, 1);
        checkVal("t6_idle_valid", if_id_valid, 0);
        tick();
        checkVal("t6_refetch", if_id_instr, 24'h600123);
        checkVal("t6_refetch_pc", if_id_pc_next, 1);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
